board_line_clear_ctrl: RTL and testbench

Sequencer that owns the 240-bit playfield grid displayed by the VGA pattern generator. On request it scans a submitted board, removes every completely filled row, and collapses the rows above downward. It commits the result to the display grid only during vertical blank, so the display never shows a partially collapsed board. It reports how many lines were cleared.

---
 rtl/board_pkg.sv | 35 +++
 rtl/board_line_clear_ctrl.sv | 169 ++++++++++++++++
 tb/tb_board_line_clear_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/board_pkg.sv
// -----------------------------------------------------------------------------
// board_pkg
// Shared definitions for the playfield grid: default geometry, the width of
// the cleared-line counter, the row-slice helper and the line-clear sequencer
// state encoding. The pattern generator imports this package as well, so both
// sides agree on which bits form which row.
//
// Row mapping: row r (0 = top) occupies grid[(ROWS-1-r)*COLS +: COLS], so
// row 0 is the most significant slice and row ROWS-1 the least significant.
// -----------------------------------------------------------------------------
package board_pkg;

    localparam int ROWS   = 20;
    localparam int COLS   = 12;
    localparam int GRID_W = ROWS * COLS;
    localparam int CNT_W  = $clog2(ROWS + 1);
    localparam int PTR_W  = $clog2(ROWS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        FILL    = 2'd2,
        WAIT_VB = 2'd3
    } state_e;

    // Extract row r of a grid using the top-row-in-MSBs mapping.
    function automatic logic [COLS-1:0] row_bits(input logic [GRID_W-1:0] grid,
                                                 input int unsigned       r);
        row_bits = '0;
        if (r < ROWS) begin
            row_bits = grid[(ROWS - 1 - int'(r)) * COLS +: COLS];
        end
    endfunction

endpackage

// File: rtl/board_line_clear_ctrl.sv
// -----------------------------------------------------------------------------
// board_line_clear_ctrl
// Owns the committed playfield grid shown by the VGA pattern generator. On a
// start request it copies the submitted board into a work register, scans it
// bottom-up one row per cycle, drops every completely filled row and collapses
// the surviving rows downward in place, then zeroes the vacated top rows. The
// result is copied to the display grid only on a clock edge where vblank is
// high, so the display never shows a half-collapsed board.
//
// Ports
//   clk           system clock
//   rst           synchronous, active-high reset (aborts any operation)
//   start         one-cycle request, honoured only while idle
//   board_in      board to process, sampled on the accepting start edge
//   vblank        high during vertical blanking; gates the commit
//   board_out     committed display grid
//   lines_cleared number of full rows removed by the last committed operation
//   busy          high whenever the sequencer is not idle
//   done          one-cycle pulse in the cycle after a commit
// -----------------------------------------------------------------------------
module board_line_clear_ctrl #(
    parameter int ROWS = board_pkg::ROWS,
    parameter int COLS = board_pkg::COLS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [ROWS*COLS-1:0]          board_in,
    input  logic                          vblank,
    output logic [ROWS*COLS-1:0]          board_out,
    output logic [$clog2(ROWS+1)-1:0]     lines_cleared,
    output logic                          busy,
    output logic                          done
);

    import board_pkg::state_e;
    import board_pkg::IDLE;
    import board_pkg::SCAN;
    import board_pkg::FILL;
    import board_pkg::WAIT_VB;

    localparam int GRID_W = ROWS * COLS;
    localparam int CNT_W  = $clog2(ROWS + 1);
    localparam int PTR_W  = $clog2(ROWS);

    localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(ROWS - 1);

    // Row read that tolerates an out-of-range pointer (the pointers wrap past
    // zero on their final decrement and are not used afterwards).
    function automatic logic [COLS-1:0] get_row(input logic [GRID_W-1:0] g,
                                                input logic [PTR_W-1:0]  r);
        get_row = '0;
        if (int'(r) < ROWS) begin
            get_row = g[(ROWS - 1 - int'(r)) * COLS +: COLS];
        end
    endfunction

    // Return g with row r replaced by v; out-of-range rows leave g untouched.
    function automatic logic [GRID_W-1:0] put_row(input logic [GRID_W-1:0] g,
                                                  input logic [PTR_W-1:0]  r,
                                                  input logic [COLS-1:0]   v);
        put_row = g;
        if (int'(r) < ROWS) begin
            put_row[(ROWS - 1 - int'(r)) * COLS +: COLS] = v;
        end
    endfunction

    state_e              state_q, state_d;
    logic [GRID_W-1:0]   work_q, work_d;
    logic [PTR_W-1:0]    rd_q, rd_d;
    logic [PTR_W-1:0]    wr_q, wr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [GRID_W-1:0]   board_out_q, board_out_d;
    logic [CNT_W-1:0]    lines_q, lines_d;
    logic                done_q, done_d;

    logic [COLS-1:0]     rd_row;
    logic                rd_full;

    assign rd_row  = get_row(work_q, rd_q);
    assign rd_full = &rd_row;

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        cnt_d       = cnt_q;
        board_out_d = board_out_q;
        lines_d     = lines_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = board_in;
                    rd_d    = LAST_ROW;
                    wr_d    = LAST_ROW;
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            end

            SCAN: begin
                // wr never drops below rd, so copying row rd down to row wr
                // never overwrites a row that still has to be read.
                if (rd_full) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    work_d = put_row(work_q, wr_q, rd_row);
                    wr_d   = wr_q - PTR_W'(1);
                end
                rd_d = rd_q - PTR_W'(1);
                if (rd_q == '0) begin
                    state_d = (cnt_d != '0) ? FILL : WAIT_VB;
                end
            end

            FILL: begin
                // After the scan wr equals count-1, so stopping once row 0 is
                // cleared takes exactly count cycles.
                work_d = put_row(work_q, wr_q, '0);
                wr_d   = wr_q - PTR_W'(1);
                if (wr_q == '0) begin
                    state_d = WAIT_VB;
                end
            end

            WAIT_VB: begin
                if (vblank) begin
                    board_out_d = work_q;
                    lines_d     = cnt_q;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            work_q      <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            cnt_q       <= '0;
            board_out_q <= '0;
            lines_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            board_out_q <= board_out_d;
            lines_q     <= lines_d;
            done_q      <= done_d;
        end
    end

    assign board_out     = board_out_q;
    assign lines_cleared = lines_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;

endmodule

// File: tb/tb_board_line_clear_ctrl.sv
module tb_board_line_clear_ctrl;

    localparam int ROWS = 20;
    localparam int COLS = 12;
    localparam int GW   = ROWS * COLS;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [GW-1:0] board_in;
    logic          vblank;
    logic [GW-1:0] board_out;
    logic [4:0]    lines_cleared;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    board_line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .board_in     (board_in),
        .vblank       (vblank),
        .board_out    (board_out),
        .lines_cleared(lines_cleared),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [GW-1:0] obs, input logic [GW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Build a board from (row, value) pairs; row 0 is the top row in the MSBs.
    function automatic logic [GW-1:0] with_row(input logic [GW-1:0] g, input int r,
                                               input logic [COLS-1:0] v);
        logic [GW-1:0] t;
        t = g;
        t[(ROWS - 1 - r) * COLS +: COLS] = v;
        return t;
    endfunction

    // Issue start with board b; returns commit edge index relative to the start
    // edge (0 if done never appears) and the number of busy cycles seen.
    task automatic run_op(input logic [GW-1:0] b, output int lat, output int busy_n);
        board_in = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        board_in = {20{12'h5A3}};
        lat      = 0;
        busy_n   = busy ? 1 : 0;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busy_n++;
        end
    endtask

    logic [GW-1:0] b2, b3, b4, e4, b19, prev;
    int            lat, bn, dcount;
    logic          held;

    initial begin
        rst = 1'b1; start = 1'b0; board_in = '0; vblank = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_board_out", board_out, '0);
        chk("rst_lines", GW'(lines_cleared), '0);
        chk("rst_busy", GW'(busy), '0);
        chk("rst_done", GW'(done), '0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Empty board: no rows cleared, commit on E21, busy 21 cycles.
        run_op('0, lat, bn);
        chk("empty_lat", GW'(lat), GW'(21));
        chk("empty_busy_cycles", GW'(bn), GW'(21));
        chk("empty_board", board_out, '0);
        chk("empty_lines", GW'(lines_cleared), '0);
        chk("empty_busy_at_done", GW'(busy), '0);
        @(posedge clk); #1;
        chk("empty_done_one_cycle", GW'(done), '0);

        // Single full bottom row.
        b2 = with_row(with_row('0, 19, 12'hFFF), 18, 12'h001);
        run_op(b2, lat, bn);
        chk("one_lat", GW'(lat), GW'(22));
        chk("one_board", board_out, GW'(12'h001));
        chk("one_lines", GW'(lines_cleared), GW'(1));

        // Four full rows, back-to-back start in the done cycle.
        b3 = with_row('0, 15, 12'hA5A);
        for (int r = 16; r < 20; r++) b3 = with_row(b3, r, 12'hFFF);
        run_op(b3, lat, bn);
        chk("four_lat", GW'(lat), GW'(25));
        chk("four_board", board_out, GW'(12'hA5A));
        chk("four_lines", GW'(lines_cleared), GW'(4));

        // Interleaved full and partial rows, plus a top-row survivor.
        b4 = with_row(with_row(with_row(with_row(with_row('0, 19, 12'hFFF), 18, 12'h800),
                      17, 12'hFFF), 16, 12'h00F), 0, 12'hFFE);
        e4 = with_row(with_row(with_row('0, 19, 12'h800), 18, 12'h00F), 2, 12'hFFE);
        run_op(b4, lat, bn);
        chk("mix_lat", GW'(lat), GW'(23));
        chk("mix_board", board_out, e4);
        chk("mix_lines", GW'(lines_cleared), GW'(2));
        @(posedge clk); #1;

        // vblank held low; extra starts while busy must be dropped.
        vblank   = 1'b0;
        prev     = board_out;
        board_in = b2;
        start    = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        dcount = 0;
        held   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            start    = (i == 3 || i == 40 || i == 90);
            board_in = '1;
            @(posedge clk); #1;
            if (done) dcount++;
            if (board_out !== prev) held = 1'b0;
        end
        start = 1'b0;
        chk("vb_low_no_done", GW'(dcount), '0);
        chk("vb_low_board_held", GW'(held), GW'(1));
        chk("vb_low_busy", GW'(busy), GW'(1));
        vblank = 1'b1;
        @(posedge clk); #1;
        chk("vb_commit_done", GW'(done), GW'(1));
        chk("vb_commit_board", board_out, GW'(12'h001));
        chk("vb_commit_lines", GW'(lines_cleared), GW'(1));
        @(posedge clk); #1;
        chk("vb_single_done", GW'(done), '0);
        chk("vb_extra_starts_dropped", GW'(busy), '0);

        // Reset at E10 of a 2-line operation.
        board_in = b4;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mid_busy_before_rst", GW'(busy), GW'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_board", board_out, '0);
        chk("mid_rst_lines", GW'(lines_cleared), '0);
        chk("mid_rst_busy", GW'(busy), '0);
        chk("mid_rst_done", GW'(done), '0);

        b19 = with_row('0, 19, 12'hFFF);
        run_op(b19, lat, bn);
        chk("post_rst_lat", GW'(lat), GW'(22));
        chk("post_rst_board", board_out, '0);
        chk("post_rst_lines", GW'(lines_cleared), GW'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
